fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path definitions: FSM states, instruction field positions,
// the queue entry layout and the default reset PC.
package core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction fields travel through the fetch path unmodified.
    localparam int INST_TYPE_LSB = 0;
    localparam int INST_TYPE_MSB = 1;
    localparam int INST_OPC_LSB  = 2;
    localparam int INST_OPC_MSB  = 6;
    localparam int INST_F3_LSB   = 12;
    localparam int INST_F3_MSB   = 14;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_HALT       = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction FIFO holding {pc, inst}; push and pop may coincide even when
// full, and flush empties it in one cycle.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    output logic [63:0]   head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][63:0] mem;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch, in-order response queue,
// redirect flush with stale-response dropping. Optional misaligned-target
// fault/halt when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   pc, resp_pc, redirect_tgt;
    logic [CW-1:0] outstanding, drop_cnt, q_count;
    logic [CW:0]   inflight;
    logic          q_empty, req_fire, resp_drop, resp_keep, misalign, fault_q;
    fetch_entry_t  q_in, q_head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
    assign misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign misalign     = 1'b0;
`endif

    // Queue slots are reserved at issue so a response always has room.
    assign inflight       = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req_valid = (state == ST_RUN) && !redirect_valid &&
                            (inflight < (CW+1)'(QDEPTH));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle is stale as well.
    assign resp_drop = imem_resp_valid && (redirect_valid || drop_cnt != '0);
    assign resp_keep = imem_resp_valid && !resp_drop;
    assign q_in      = '{pc: resp_pc, inst: imem_resp_data};

    fetch_queue #(.DEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data (q_in),
        .pop       (inst_ready),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign inst_valid  = !q_empty;
    assign inst        = q_head.inst;
    assign inst_pc     = q_head.pc;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET_WAIT;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fault_q     <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (req_fire)
                pc <= pc_next(pc);

            // resp_pc tracks the address of the next response that is kept.
            if (redirect_valid) begin
                pc       <= redirect_tgt;
                resp_pc  <= redirect_tgt;
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (resp_keep)
                    resp_pc <= pc_next(resp_pc);
                if (resp_drop)
                    drop_cnt <= drop_cnt - CW'(1);
            end

            case (state)
                ST_RESET_WAIT: state <= ST_RUN;
                ST_RUN:        state <= ST_RUN;
                default:       state <= ST_HALT;
            endcase
            if (misalign) begin
                state   <= ST_HALT;
                fault_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an epoch-tagged transaction model.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_addr, imem_resp_data;
    logic        inst_valid, inst_ready, redirect_valid, fetch_fault;
    logic [31:0] inst, inst_pc, redirect_pc;

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    mreq_t       mem_q[$];   // accepted requests awaiting response
    ent_t        mq[$];      // instructions the decoder should see
    logic [31:0] acc_log[$], pop_log[$];
    int          n_tests, n_fail, cyc, epoch, first_iv;
    int          p_ready, p_irdy, lat_lo, lat_hi;
    logic [31:0] exp_pc;
    bit          halted, exp_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
        w[INST_TYPE_MSB:INST_TYPE_LSB] = 2'b11;
        w[INST_OPC_MSB:INST_OPC_LSB]   = a[6:2];
        w[INST_F3_MSB:INST_F3_LSB]     = a[4:2];
        return w;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, check, advance model, wait.
    task automatic step(input bit rv, input logic [31:0] rpc);
        bit    exp_req, fire, have_resp, kept, popd;
        mreq_t r;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_req_ready  = ($urandom_range(99) < p_ready);
        inst_ready      = ($urandom_range(99) < p_irdy);
        have_resp       = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = have_resp;
        imem_resp_data  = have_resp ? mem_q[0].data : $urandom;
        #1;
        exp_req = (cyc >= 1) && !halted && !rv && (mq.size() + mem_q.size() < QD);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_pc);
        chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst", inst, mq[0].inst);
            chk("inst_pc", inst_pc, mq[0].pc);
        end
        chk("fault", 32'(fetch_fault), 32'(exp_fault));
        if (inst_valid && first_iv < 0) first_iv = cyc;

        fire = exp_req && imem_req_ready;
        popd = (mq.size() != 0) && inst_ready;
        if (popd) begin
            pop_log.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        kept = 1'b0;
        if (have_resp) begin
            r    = mem_q.pop_front();
            kept = !rv && (r.epoch == epoch);
        end
        if (fire) begin
            acc_log.push_back(exp_pc);
            mem_q.push_back('{addr: exp_pc, data: mem_word(exp_pc), epoch: epoch,
                              due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            exp_pc += 32'd4;
        end
        if (rv) begin
            mq.delete();
            epoch++;
            exp_pc = rpc & PC_MASK;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) begin
                halted    = 1'b1;
                exp_fault = 1'b1;
            end
`endif
        end else if (kept) begin
            mq.push_back('{pc: r.addr, inst: r.data});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
        mem_q.delete(); mq.delete(); acc_log.delete(); pop_log.delete();
        epoch = 0; exp_pc = RPC; halted = 1'b0; exp_fault = 1'b0; first_iv = -1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        bit found;
        n_tests = 0; n_fail = 0; cyc = 0;
        p_ready = 100; p_irdy = 100; lat_lo = 1; lat_hi = 1;

        // Straight-line fetch at minimum latency
        do_reset();
        repeat (12) step(1'b0, '0);
        chk("first_inst_cyc", 32'(first_iv), 32'd3);
        chk("addr0", pick(acc_log, 0), 32'h0);
        chk("addr1", pick(acc_log, 1), 32'h4);
        chk("addr2", pick(acc_log, 2), 32'h8);
        chk("pc0", pick(pop_log, 0), 32'h0);
        chk("pc1", pick(pop_log, 1), 32'h4);
        chk("pc2", pick(pop_log, 2), 32'h8);

        // Decoder stall: only QDEPTH requests, nothing lost afterwards
        do_reset();
        p_irdy = 0;
        repeat (10) step(1'b0, '0);
        chk("stall_reqs", 32'(acc_log.size()), 32'(QD));
        p_irdy = 100;
        repeat (10) step(1'b0, '0);
        chk("stall_pc0", pick(pop_log, 0), 32'h0);
        chk("stall_pc1", pick(pop_log, 1), 32'h4);

        // Redirect with two requests in flight
        do_reset();
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() >= 2) found = 1'b1;
            else step(1'b0, '0);
        end
        chk("redir_setup", 32'(found), 32'd1);
        step(1'b1, 32'h100);
        pop_log.delete();
        repeat (15) step(1'b0, '0);
        chk("redir_pc", pick(pop_log, 0), 32'h100);

        // Redirect coinciding with a response and an instruction handshake
        do_reset();
        lat_lo = 1; lat_hi = 1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc) found = 1'b1;
            else step(1'b0, '0);
        end
        chk("same_cyc_setup", 32'(found), 32'd1);
        pop_log.delete();
        step(1'b1, 32'h200);
        chk("same_cyc_pop", 32'(pop_log.size()), 32'd1);
        redirect_valid = 1'b0;
        #1 chk("same_cyc_empty", 32'(inst_valid), 32'd0);
        repeat (8) step(1'b0, '0);

        // PC wrap at the top of the address space
        acc_log.delete();
        step(1'b1, 32'hFFFF_FFFC);
        repeat (10) step(1'b0, '0);
        chk("wrap0", pick(acc_log, 0), 32'hFFFF_FFFC);
        chk("wrap1", pick(acc_log, 1), 32'h0000_0000);

        // Misaligned redirect target
        acc_log.delete();
        step(1'b1, 32'h102);
        repeat (10) step(1'b0, '0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_noreq", 32'(acc_log.size()), 32'd0);
`else
        chk("mis_fault", 32'(fetch_fault), 32'd0);
        chk("mis_addr", pick(acc_log, 0), 32'h100);
`endif

        // Random traffic, latency, back-pressure and redirects
        do_reset();
        p_ready = 70; p_irdy = 65; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            bit          rv;
            rv = (cyc >= 2) && ($urandom_range(99) < 3);
            t  = $urandom;
            if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0;
`ifdef FETCH_MISALIGN_CHECK_EN
            t[1:0] = 2'b00;
`endif
            step(rv, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
